// File: rtl/ariane_reset_irq_sequencer.sv
// Core reset-release sequencer and N-channel interrupt synchroniser for an Ariane tile.
// Optional wake-on-interrupt hold stage is enabled by defining ARIANE_WAKE_ON_IRQ_EN.
module ariane_reset_irq_sequencer #(
  parameter int unsigned        NumIrq        = 5,
  parameter int unsigned        SyncStages    = 2,
  parameter int unsigned        WakeCntWidth  = 16,
  parameter int unsigned        WakeCycles    = 32768,
  parameter int unsigned        SoftRstCycles = 16,
  parameter logic [NumIrq-1:0]  EdgeMask      = '0
) (
  input  logic                    clk_i,
  input  logic                    reset_l,
  input  logic [NumIrq-1:0]       irq_async_i,
  input  logic [NumIrq-1:0]       irq_clr_i,
  input  logic                    soft_rst_req_i,
  input  logic                    wake_req_i,
  output logic                    core_rst_no,
  output logic [NumIrq-1:0]       irq_o,
  output logic [1:0]              state_o,
  output logic [WakeCntWidth-1:0] wake_cnt_o
);

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    WAIT_WAKE = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam int unsigned RelW = $clog2(SyncStages) + 1;
  localparam logic [WakeCntWidth-1:0] WakeTgt = WakeCntWidth'(WakeCycles - 1);
  localparam logic [WakeCntWidth-1:0] SoftTgt = WakeCntWidth'(SoftRstCycles - 1);
  localparam logic [RelW-1:0]         RelTgt  = RelW'(SyncStages - 1);

  if (WakeCycles < 1 || longint'(WakeCycles) > (longint'(1) << WakeCntWidth)) begin : g_bad_wake
    $error("WakeCycles out of range for WakeCntWidth");
  end
  if (SoftRstCycles < 1 || longint'(SoftRstCycles) > (longint'(1) << WakeCntWidth)) begin : g_bad_soft
    $error("SoftRstCycles out of range for WakeCntWidth");
  end
  if (SyncStages < 2) begin : g_bad_sync
    $error("SyncStages must be at least 2");
  end

  state_e                  state_q, state_d;
  logic [WakeCntWidth-1:0] wake_cnt_q, wake_cnt_d;
  logic [RelW-1:0]         rel_cnt_q, rel_cnt_d;
  logic                    soft_q, soft_d;
  logic                    core_rst_q, core_rst_d;
  logic [NumIrq-1:0]       sync_w;
  logic                    run_w;

  assign run_w = (state_q == RUN);

  always_comb begin
    state_d    = state_q;
    wake_cnt_d = wake_cnt_q;
    rel_cnt_d  = rel_cnt_q;
    soft_d     = soft_q;
    case (state_q)
      HOLD: begin
        if (wake_cnt_q == (soft_q ? SoftTgt : WakeTgt)) begin
          wake_cnt_d = '0;
`ifdef ARIANE_WAKE_ON_IRQ_EN
          state_d    = soft_q ? RELEASE : WAIT_WAKE;
`else
          state_d    = RELEASE;
`endif
        end else begin
          wake_cnt_d = wake_cnt_q + 1'b1;
        end
      end
      WAIT_WAKE: begin
`ifdef ARIANE_WAKE_ON_IRQ_EN
        if (wake_req_i || (|sync_w)) state_d = RELEASE;
`else
        state_d = RELEASE;
`endif
      end
      RELEASE: begin
        if (rel_cnt_q == RelTgt) begin
          rel_cnt_d = '0;
          soft_d    = 1'b0;
          state_d   = RUN;
        end else begin
          rel_cnt_d = rel_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (soft_rst_req_i) begin
          state_d    = HOLD;
          soft_d     = 1'b1;
          wake_cnt_d = '0;
        end
      end
      default: state_d = HOLD;
    endcase
  end

  // Reset drops on the very edge a soft request leaves RUN, not one cycle later.
  assign core_rst_d = (state_q == RUN) && (state_d == RUN);

  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      state_q    <= HOLD;
      wake_cnt_q <= '0;
      rel_cnt_q  <= '0;
      soft_q     <= 1'b0;
      core_rst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wake_cnt_q <= wake_cnt_d;
      rel_cnt_q  <= rel_cnt_d;
      soft_q     <= soft_d;
      core_rst_q <= core_rst_d;
    end
  end

  for (genvar gi = 0; gi < NumIrq; gi++) begin : g_irq
    logic [SyncStages-1:0] sync_q;

    always_ff @(posedge clk_i or negedge reset_l) begin
      if (!reset_l) sync_q <= '0;
      else          sync_q <= {sync_q[SyncStages-2:0], irq_async_i[gi]};
    end
    assign sync_w[gi] = sync_q[SyncStages-1];

    if (EdgeMask[gi]) begin : g_edge
      logic sync_dly_q, pend_q, pend_d;

      // A new edge beats a simultaneous clear so no interrupt is lost.
      always_comb begin
        pend_d = pend_q;
        if (!run_w)                          pend_d = 1'b0;
        else if (sync_w[gi] && !sync_dly_q)  pend_d = 1'b1;
        else if (irq_clr_i[gi])              pend_d = 1'b0;
      end

      always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
          sync_dly_q <= 1'b0;
          pend_q     <= 1'b0;
        end else begin
          sync_dly_q <= sync_w[gi];
          pend_q     <= pend_d;
        end
      end
      assign irq_o[gi] = pend_q;
    end else begin : g_level
      assign irq_o[gi] = sync_w[gi] & run_w;
    end
  end

  logic [NumIrq-1:0] unused_clr;
  assign unused_clr = irq_clr_i;
`ifndef ARIANE_WAKE_ON_IRQ_EN
  logic unused_wake;
  assign unused_wake = wake_req_i;
`endif

  assign core_rst_no = core_rst_q;
  assign state_o     = state_q;
  assign wake_cnt_o  = wake_cnt_q;

endmodule

// File: tb/tb_ariane_reset_irq_sequencer.sv
// Directed bench for ariane_reset_irq_sequencer: reset release, soft reset, level/edge irq paths and gating.
module tb_ariane_reset_irq_sequencer;
  localparam int NI   = 5;
  localparam int WAKE = 8;

  logic          clk_i = 1'b0;
  logic          reset_l = 1'b0;
  logic [NI-1:0] irq_async_i = '0;
  logic [NI-1:0] irq_clr_i = '0;
  logic          soft_rst_req_i = 1'b0;
  logic          wake_req_i = 1'b0;
  logic          core_rst_no;
  logic [NI-1:0] irq_o;
  logic [1:0]    state_o;
  logic [15:0]   wake_cnt_o;

  ariane_reset_irq_sequencer #(
    .NumIrq(NI), .SyncStages(2), .WakeCntWidth(16),
    .WakeCycles(WAKE), .SoftRstCycles(4), .EdgeMask(5'b00010)
  ) dut (
    .clk_i(clk_i), .reset_l(reset_l), .irq_async_i(irq_async_i),
    .irq_clr_i(irq_clr_i), .soft_rst_req_i(soft_rst_req_i), .wake_req_i(wake_req_i),
    .core_rst_no(core_rst_no), .irq_o(irq_o), .state_o(state_o), .wake_cnt_o(wake_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic expect_out(input string tag, input int st, input int cnt,
                            input bit core, input logic [NI-1:0] irq);
    push({tag, ".state"}, 32'(st));
    push({tag, ".wake_cnt"}, 32'(cnt));
    push({tag, ".core_rst_no"}, {31'b0, core});
    push({tag, ".irq"}, {27'b0, irq});
  endtask

  task automatic compare_out();
    pop_check({30'b0, state_o});
    pop_check({16'b0, wake_cnt_o});
    pop_check({31'b0, core_rst_no});
    pop_check({27'b0, irq_o});
  endtask

  task automatic step(input string tag, input int st, input int cnt,
                      input bit core, input logic [NI-1:0] irq);
    expect_out(tag, st, cnt, core, irq);
    @(posedge clk_i);
    @(negedge clk_i);
    compare_out();
  endtask

  task automatic tile_reset();
    reset_l = 1'b0;
    repeat (3) @(negedge clk_i);
    expect_out("in_reset", 0, 0, 1'b0, '0);
    compare_out();
    reset_l = 1'b1;
    for (int i = 1; i < WAKE; i++) step("hold", 0, i, 1'b0, '0);
`ifdef ARIANE_WAKE_ON_IRQ_EN
    for (int i = 0; i < 50; i++) step("wait_wake", 1, 0, 1'b0, '0);
    wake_req_i = 1'b1;
    step("wake", 2, 0, 1'b0, '0);
    wake_req_i = 1'b0;
    step("release", 2, 0, 1'b0, '0);
`else
    step("release", 2, 0, 1'b0, '0);
    step("release", 2, 0, 1'b0, '0);
`endif
    step("run", 3, 0, 1'b0, '0);
    step("core_up", 3, 0, 1'b1, '0);
  endtask

  initial begin
    tile_reset();

    // Soft reset: low on the request edge, ignored while in HOLD, back up 7 edges later.
    soft_rst_req_i = 1'b1;
    step("soft", 0, 0, 1'b0, '0);
    soft_rst_req_i = 1'b0;
    step("soft_hold", 0, 1, 1'b0, '0);
    soft_rst_req_i = 1'b1;
    step("soft_ignored", 0, 2, 1'b0, '0);
    soft_rst_req_i = 1'b0;
    step("soft_hold", 0, 3, 1'b0, '0);
    step("soft_rel", 2, 0, 1'b0, '0);
    step("soft_rel", 2, 0, 1'b0, '0);
    step("soft_run", 3, 0, 1'b0, '0);
    step("soft_core_up", 3, 0, 1'b1, '0);

    // Level channel 0, including a clear that must have no effect.
    irq_async_i[0] = 1'b1;
    step("lvl_sync1", 3, 0, 1'b1, 5'b00000);
    step("lvl_rise", 3, 0, 1'b1, 5'b00001);
    irq_clr_i[0] = 1'b1;
    step("lvl_clr_noop", 3, 0, 1'b1, 5'b00001);
    irq_clr_i[0] = 1'b0;
    irq_async_i[0] = 1'b0;
    step("lvl_fall1", 3, 0, 1'b1, 5'b00001);
    step("lvl_fall", 3, 0, 1'b1, 5'b00000);

    // Edge channel 1: 2-cycle pulse, coincident set/clear, lone clear.
    irq_async_i[1] = 1'b1;
    step("edge_s1", 3, 0, 1'b1, 5'b00000);
    step("edge_s2", 3, 0, 1'b1, 5'b00000);
    irq_async_i[1] = 1'b0;
    step("edge_pend", 3, 0, 1'b1, 5'b00010);
    step("edge_held", 3, 0, 1'b1, 5'b00010);
    step("edge_held", 3, 0, 1'b1, 5'b00010);
    irq_async_i[1] = 1'b1;
    step("edge_b1", 3, 0, 1'b1, 5'b00010);
    step("edge_b2", 3, 0, 1'b1, 5'b00010);
    irq_clr_i[1] = 1'b1;
    step("edge_set_wins", 3, 0, 1'b1, 5'b00010);
    irq_clr_i[1] = 1'b0;
    irq_async_i[1] = 1'b0;
    step("edge_still", 3, 0, 1'b1, 5'b00010);
    irq_clr_i[1] = 1'b1;
    step("edge_clr", 3, 0, 1'b1, 5'b00000);
    irq_clr_i[1] = 1'b0;
    step("edge_idle", 3, 0, 1'b1, 5'b00000);

    // Interrupt pulses while held in reset are discarded.
    soft_rst_req_i = 1'b1;
    step("gate_soft", 0, 0, 1'b0, '0);
    soft_rst_req_i = 1'b0;
    irq_async_i = 5'b00011;
    step("gate_hold", 0, 1, 1'b0, '0);
    step("gate_hold", 0, 2, 1'b0, '0);
    irq_async_i = '0;
    step("gate_hold", 0, 3, 1'b0, '0);
    step("gate_rel", 2, 0, 1'b0, '0);
    step("gate_rel", 2, 0, 1'b0, '0);
    step("gate_run", 3, 0, 1'b0, '0);
    step("gate_core_up", 3, 0, 1'b1, '0);
    step("gate_no_pend", 3, 0, 1'b1, '0);

    // Pend an edge interrupt, then pull tile reset mid-cycle.
    irq_async_i[1] = 1'b1;
    step("pre_rst_s1", 3, 0, 1'b1, 5'b00000);
    step("pre_rst_s2", 3, 0, 1'b1, 5'b00000);
    irq_async_i[1] = 1'b0;
    step("pre_rst_pend", 3, 0, 1'b1, 5'b00010);
    #2 reset_l = 1'b0;
    #1;
    expect_out("async_rst", 0, 0, 1'b0, '0);
    compare_out();
    tile_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
